// File: rtl/spike_vote_window.sv
// spike_vote_window: counts one-hot winner spikes per neuron lane over a
// window of p_window input events plus a p_tail-cycle drain, then presents
// the lane with the most spikes (lowest lane on a tie) to the host.
// Optional build macro SPIKE_VOTE_TIE_EN compiles in tie detection on o_tie;
// without it o_tie is tied to 0.
// Handshake: o_valid is high for every cycle the block is in HOLD, and the
// decision outputs do not change while it is high. The decision is consumed
// on the first rising clock edge where o_valid and i_ready are both 1. The
// block then returns to IDLE and o_valid is low in the following cycle.
// o_dbg_state exposes the FSM state encoding for observation.
module spike_vote_window #(
  parameter int p_n         = 4,
  parameter int p_idx_width = 2,
  parameter int p_cnt_width = 8,
  parameter int p_window    = 16,
  parameter int p_ev_width  = 5,
  parameter int p_tail      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_event_valid,
  input  logic [p_n:1]           i_spike,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [p_idx_width-1:0] o_class,
  output logic [p_cnt_width-1:0] o_count_max,
  output logic                   o_tie,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    TAIL   = 3'd2,
    DECIDE = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam int TW = (p_tail > 1) ? $clog2(p_tail) : 1;
  localparam logic [p_ev_width-1:0] EV_LAST   = p_ev_width'(p_window - 1);
  localparam logic [TW-1:0]         TAIL_LAST = TW'((p_tail > 0) ? p_tail - 1 : 0);

  state_e                   state_q, state_d;
  logic [p_ev_width-1:0]    ev_q, ev_d;
  logic [TW-1:0]            tail_q, tail_d;
  logic [p_cnt_width-1:0]   cnt_q [p_n:1];
  logic [p_cnt_width-1:0]   cnt_d [p_n:1];
  logic [p_idx_width-1:0]   class_q, class_d;
  logic [p_cnt_width-1:0]   max_q, max_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [p_idx_width-1:0]   best_idx;
  logic [p_cnt_width-1:0]   best_cnt;

  // Argmax over the lane counters; strict '>' keeps the lowest lane on a tie
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int k = 1; k <= p_n; k++) begin
      if (cnt_q[k] > best_cnt) begin
        best_cnt = cnt_q[k];
        best_idx = p_idx_width'(k - 1);
      end
    end
  end

`ifdef SPIKE_VOTE_TIE_EN
  logic tie_q, tie_d;
  logic best_tie;
  logic seen_max;

  // Tie when a second lane matches the max (all-zero counts as a tie)
  always_comb begin
    best_tie = 1'b0;
    seen_max = 1'b0;
    for (int k = 1; k <= p_n; k++) begin
      if (cnt_q[k] == best_cnt) begin
        if (seen_max) best_tie = 1'b1;
        seen_max = 1'b1;
      end
    end
  end

  // Tie flag register, loaded in DECIDE
  always_ff @(posedge i_clk) begin
    if (i_rst) tie_q <= 1'b0;
    else       tie_q <= tie_d;
  end

  // Tie next-value select
  always_comb begin
    tie_d = tie_q;
    if (state_q == DECIDE) tie_d = best_tie;
  end

  assign o_tie = tie_q;
`else
  assign o_tie = 1'b0;
`endif

  // Next-state, counters and decision capture
  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE: begin
        ev_d   = '0;
        tail_d = '0;
        for (int k = 1; k <= p_n; k++) cnt_d[k] = '0;
        if (i_start) state_d = COUNT;
      end
      COUNT: begin
        for (int k = 1; k <= p_n; k++) begin
          if (i_spike[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
        end
        if (i_event_valid) begin
          ev_d = ev_q + 1'b1;
          if (ev_q == EV_LAST) begin
            tail_d  = '0;
            state_d = (p_tail == 0) ? DECIDE : TAIL;
          end
        end
      end
      TAIL: begin
        for (int k = 1; k <= p_n; k++) begin
          if (i_spike[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
        end
        tail_d = tail_q + 1'b1;
        if (tail_q == TAIL_LAST) state_d = DECIDE;
      end
      DECIDE: begin
        class_d = best_idx;
        max_d   = best_cnt;
        state_d = HOLD;
      end
      HOLD: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == COUNT) || (state_d == TAIL) || (state_d == DECIDE);
    valid_d = (state_d == HOLD);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ev_q    <= '0;
      tail_q  <= '0;
      for (int k = 1; k <= p_n; k++) cnt_q[k] <= '0;
      class_q <= '0;
      max_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
      max_q   <= max_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_class     = class_q;
  assign o_count_max = max_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spike_vote_window.sv
// Bench for spike_vote_window: small window (4 events, 2 tail cycles) and a
// 3-bit counter so saturation is reachable. Expected decisions come from a
// lane-count model and travel through a scoreboard queue.
module tb_spike_vote_window;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int CW   = 3;
  localparam int WIN  = 4;
  localparam int EVW  = 3;
  localparam int TAIL = 2;
  localparam int SAT  = (1 << CW) - 1;
  localparam int W    = IW + CW + 1;

  // clock / reset / signals
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_event_valid = 1'b0;
  logic [N:1]    i_spike = '0;
  logic          i_ready = 1'b0;
  logic          o_busy;
  logic          o_valid;
  logic [IW-1:0] o_class;
  logic [CW-1:0] o_count_max;
  logic          o_tie;
  logic [2:0]    o_dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int ev_cyc = 0;
  int mcnt [1:N];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] cur;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  spike_vote_window #(
    .p_n(N), .p_idx_width(IW), .p_cnt_width(CW),
    .p_window(WIN), .p_ev_width(EVW), .p_tail(TAIL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_event_valid(i_event_valid), .i_spike(i_spike), .i_ready(i_ready),
    .o_busy(o_busy), .o_valid(o_valid), .o_class(o_class),
    .o_count_max(o_count_max), .o_tie(o_tie), .o_dbg_state(o_dbg_state)
  );

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 1; k <= N; k++) mcnt[k] = 0;
  endtask

  task automatic start_window();
    model_clear();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    @(negedge i_clk);
    check("busy_rise", o_busy, 1);
  endtask

  // cycle the DUT counts (COUNT or TAIL): model tracks the spikes
  task automatic count_cycle(input logic ev, input logic [N:1] spk);
    i_event_valid = ev;
    i_spike = spk;
    if (ev) ev_cyc = cyc;
    for (int k = 1; k <= N; k++)
      if (spk[k] && mcnt[k] < SAT) mcnt[k]++;
    tick();
    i_event_valid = 1'b0;
    i_spike = '0;
  endtask

  // cycle the DUT must ignore (DECIDE/HOLD)
  task automatic dead_cycle(input logic [N:1] spk);
    i_spike = spk;
    i_event_valid = 1'b1;
    tick();
    i_spike = '0;
    i_event_valid = 1'b0;
  endtask

  task automatic push_expect();
    int best, bi, neq;
    logic t;
    best = 0; bi = 0; neq = 0;
    for (int k = 1; k <= N; k++)
      if (mcnt[k] > best) begin best = mcnt[k]; bi = k - 1; end
    for (int k = 1; k <= N; k++)
      if (mcnt[k] == best) neq++;
`ifdef SPIKE_VOTE_TIE_EN
    t = (neq > 1);
`else
    t = 1'b0;
`endif
    exp_q.push_back({IW'(bi), CW'(best), t});
  endtask

  // scoreboard: wait for o_valid, pop expected, compare
  task automatic wait_decision(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_valid) begin got = 1'b1; break; end
    end
    check({tag, "_valid_seen"}, got, 1);
    check({tag, "_exp_avail"}, exp_q.size() != 0, 1);
    if (got && exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check({tag, "_latency"}, cyc - ev_cyc, TAIL + 2);
      check({tag, "_class"}, o_class, cur[W-1:W-IW]);
      check({tag, "_count_max"}, o_count_max, cur[CW:1]);
      check({tag, "_tie"}, o_tie, cur[0]);
      check({tag, "_busy_hold"}, o_busy, 0);
    end
  endtask

  task automatic release_hold(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    @(negedge i_clk);
    check({tag, "_valid_drop"}, o_valid, 0);
    check({tag, "_idle"}, o_dbg_state, 0);
  endtask

  task automatic tail_plain();
    for (int t = 0; t < TAIL; t++) count_cycle(1'b0, '0);
    push_expect();
  endtask

  initial begin
    // reset
    tick(); tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_class", o_class, 0);
    check("rst_count_max", o_count_max, 0);
    check("rst_tie", o_tie, 0);
    check("rst_state", o_dbg_state, 0);

    // basic window: lane 3 x3, lane 1 x1
    start_window();
    count_cycle(1'b1, 4'b0100);
    count_cycle(1'b1, 4'b0100);
    count_cycle(1'b1, 4'b0100);
    count_cycle(1'b1, 4'b0001);
    @(negedge i_clk);
    check("tail_busy", o_busy, 1);
    tail_plain();
    wait_decision("basic");
    release_hold("basic");

    // tie between lanes 2 and 4
    start_window();
    count_cycle(1'b1, 4'b0010);
    count_cycle(1'b1, 4'b1000);
    count_cycle(1'b0, 4'b1010);
    count_cycle(1'b1, 4'b0000);
    count_cycle(1'b1, 4'b0000);
    tail_plain();
    wait_decision("tie");
    release_hold("tie");

    // tail capture, late spikes ignored, HOLD stall with i_start ignored
    start_window();
    for (int e = 0; e < WIN; e++) count_cycle(1'b1, '0);
    count_cycle(1'b0, '0);
    count_cycle(1'b0, 4'b1000);
    push_expect();
    dead_cycle(4'b1000);
    wait_decision("late");
    i_start = 1'b1;
    for (int s = 0; s < 5; s++) begin
      i_spike = 4'b1000;
      @(negedge i_clk);
      check("stall_valid", o_valid, 1);
      check("stall_class", o_class, cur[W-1:W-IW]);
      check("stall_count_max", o_count_max, cur[CW:1]);
      check("stall_tie", o_tie, cur[0]);
    end
    i_start = 1'b0;
    i_spike = '0;
    release_hold("stall");
    @(negedge i_clk);
    check("start_in_hold_ignored", o_busy, 0);

    // saturation with i_ready already high before HOLD
    start_window();
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) count_cycle((c % 3) == 2, 4'b0001);
    tail_plain();
    wait_decision("sat");
    @(negedge i_clk);
    check("sat_early_ready_drop", o_valid, 0);
    i_ready = 1'b0;

    // reset mid-window
    start_window();
    count_cycle(1'b1, 4'b0100);
    count_cycle(1'b1, 4'b0100);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_class", o_class, 0);
    check("mid_rst_count_max", o_count_max, 0);
    check("mid_rst_tie", o_tie, 0);
    start_window();
    for (int e = 0; e < WIN; e++) count_cycle(1'b1, '0);
    tail_plain();
    wait_decision("empty");
    release_hold("empty");

    // random windows
    for (int r = 0; r < 3; r++) begin
      int nev;
      nev = 0;
      start_window();
      for (int c = 0; c < 40 && nev < WIN; c++) begin
        logic ev;
        ev = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        if (ev) nev++;
        count_cycle(ev, N'($urandom_range(0, 15)));
      end
      for (int t = 0; t < TAIL; t++) count_cycle(1'b0, N'($urandom_range(0, 15)));
      push_expect();
      wait_decision("rand");
      release_hold("rand");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
